// File: rtl/gsim_pkg.sv
// Shared types and sizing for the Gauss-Seidel sequencer.
package gsim_pkg;

    localparam int unsigned N       = 16;
    localparam int unsigned N_HALF  = N / 2;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned SWEEP_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_DRAIN,
        ST_OUT
    } state_e;

    // One PE issue slot as it travels down the writeback delay line.
    typedef struct packed {
        logic             issue;
        logic [ROW_W-1:0] row0;
        logic [ROW_W-1:0] row1;
    } wb_slot_t;

endpackage

// File: rtl/gsim_sched_if.sv
// Handshake, b/x buffer and PE control bundle of the solver sequencer.
interface gsim_sched_if;
    import gsim_pkg::*;

    logic               in_en;
    logic               b_we;
    logic [ROW_W-1:0]   b_addr;
    logic               pe_issue;
    logic [ROW_W-1:0]   pe_row0;
    logic [ROW_W-1:0]   pe_row1;
    logic               x_we;
    logic [ROW_W-1:0]   x_waddr0;
    logic [ROW_W-1:0]   x_waddr1;
    logic [SWEEP_W-1:0] sweep_cnt;
    logic               out_valid;
    logic [ROW_W-1:0]   out_addr;
    logic               busy;

    modport slave (
        input  in_en,
        output b_we, b_addr, pe_issue, pe_row0, pe_row1,
        output x_we, x_waddr0, x_waddr1, sweep_cnt, out_valid, out_addr, busy
    );

    modport master (
        output in_en,
        input  b_we, b_addr, pe_issue, pe_row0, pe_row1,
        input  x_we, x_waddr0, x_waddr1, sweep_cnt, out_valid, out_addr, busy
    );

endinterface

// File: rtl/gsim_wb_delay.sv
// PE_LAT-deep shift register aligning issue slots with PE results.
module gsim_wb_delay
    import gsim_pkg::*;
#(
    parameter int unsigned PE_LAT = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  wb_slot_t slot_i,
    output wb_slot_t slot_o
);

    wb_slot_t [PE_LAT-1:0] pipe_q;
    wb_slot_t [PE_LAT-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = slot_i;
        for (int i = 1; i < int'(PE_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign slot_o = pipe_q[PE_LAT-1];

endmodule

// File: rtl/gsim_sched.sv
// Gauss-Seidel sequencer: loads b, runs NR_ITER sweeps over two PEs, streams x out.
module gsim_sched
    import gsim_pkg::*;
#(
    parameter int unsigned NR_ITER = 84,
    parameter int unsigned PE_LAT  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    gsim_sched_if.slave  bus
);

    localparam int unsigned          DRN_W     = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [DRN_W-1:0]     DRN_LAST  = DRN_W'(PE_LAT - 1);
    localparam logic [SWEEP_W-1:0]   SWEEP_END = SWEEP_W'(NR_ITER);
    localparam logic [ROW_W-1:0]     IDX_LAST  = ROW_W'(N - 1);
    localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(N_HALF - 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [ROW_W-1:0]   out_cnt_q, out_cnt_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic               pe_issue_q, pe_issue_d;
    logic [ROW_W-1:0]   pe_row0_q, pe_row0_d;
    logic [ROW_W-1:0]   pe_row1_q, pe_row1_d;
    logic               out_valid_q, out_valid_d;
    logic [ROW_W-1:0]   out_addr_q, out_addr_d;
    logic               busy_q, busy_d;
    logic               b_we_c;
    logic [ROW_W-1:0]   b_addr_c;
    wb_slot_t           wb_in, wb_out;

    // Next state, counters and lookahead for the registered outputs.
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        out_cnt_d = out_cnt_q;
        slot_d    = slot_q;
        drn_d     = drn_q;
        sweep_d   = sweep_q;
        b_we_c    = 1'b0;
        b_addr_c  = '0;

        case (state_q)
            ST_IDLE: begin
                b_we_c = bus.in_en;
                if (bus.in_en) begin
                    state_d  = ST_LOAD;
                    ld_cnt_d = ROW_W'(1);
                end
            end
            ST_LOAD: begin
                b_we_c   = bus.in_en;
                b_addr_c = ld_cnt_q;
                if (bus.in_en) begin
                    if (ld_cnt_q == IDX_LAST) begin
                        state_d = ST_CALC;
                        slot_d  = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + ROW_W'(1);
                    end
                end
            end
            ST_CALC: begin
                if (slot_q == SLOT_LAST) begin
                    state_d = ST_DRAIN;
                    drn_d   = '0;
                    if (DRN_LAST == '0) begin
                        sweep_d = sweep_q + SWEEP_W'(1);
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    if (sweep_q == SWEEP_END) begin
                        state_d   = ST_OUT;
                        out_cnt_d = '0;
                    end else begin
                        state_d = ST_CALC;
                        slot_d  = '0;
                    end
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                    // Count lands on the final drain cycle, where the last writeback lands.
                    if (drn_d == DRN_LAST) begin
                        sweep_d = sweep_q + SWEEP_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (out_cnt_q == IDX_LAST) begin
                    state_d  = ST_IDLE;
                    sweep_d  = '0;
                    ld_cnt_d = '0;
                end else begin
                    out_cnt_d = out_cnt_q + ROW_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pe_issue_d  = (state_d == ST_CALC);
        pe_row0_d   = pe_issue_d ? ROW_W'(slot_d) : '0;
        pe_row1_d   = pe_issue_d ? (ROW_W'(slot_d) + ROW_W'(N_HALF)) : '0;
        out_valid_d = (state_d == ST_OUT);
        out_addr_d  = out_valid_d ? out_cnt_d : '0;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ld_cnt_q    <= '0;
            out_cnt_q   <= '0;
            slot_q      <= '0;
            drn_q       <= '0;
            sweep_q     <= '0;
            pe_issue_q  <= 1'b0;
            pe_row0_q   <= '0;
            pe_row1_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            out_cnt_q   <= out_cnt_d;
            slot_q      <= slot_d;
            drn_q       <= drn_d;
            sweep_q     <= sweep_d;
            pe_issue_q  <= pe_issue_d;
            pe_row0_q   <= pe_row0_d;
            pe_row1_q   <= pe_row1_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
        end
    end

    assign wb_in = '{issue: pe_issue_q, row0: pe_row0_q, row1: pe_row1_q};

    gsim_wb_delay #(
        .PE_LAT (PE_LAT)
    ) u_wb_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .slot_i (wb_in),
        .slot_o (wb_out)
    );

    assign bus.b_we      = b_we_c;
    assign bus.b_addr    = b_addr_c;
    assign bus.pe_issue  = pe_issue_q;
    assign bus.pe_row0   = pe_row0_q;
    assign bus.pe_row1   = pe_row1_q;
    assign bus.x_we      = wb_out.issue;
    assign bus.x_waddr0  = wb_out.row0;
    assign bus.x_waddr1  = wb_out.row1;
    assign bus.sweep_cnt = sweep_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gsim_sched.sv
// Bench for gsim_sched: default instance (84 sweeps, latency 2) and short instance (1 sweep, latency 3).
module tb_gsim_sched;

    typedef struct {
        int rst_n, in_en;
        int b_we, b_addr, pe_issue, row0, row1;
        int x_we, wa0, wa1, sweep, out_valid, out_addr, busy;
    } view_t;

    localparam int NRV [2]     = '{84, 1};
    localparam int LATV [2]    = '{2, 3};
    localparam int LIT_ISS [2] = '{672, 8};
    localparam int LIT_LAT [2] = '{841, 12};

    logic clk;
    logic rst_a_n, rst_b_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int mdl_ld [2]    = '{0, 0};
    int mdl_start [2] = '{0, 0};
    int n_iss [2]     = '{0, 0};
    int n_xwe [2]     = '{0, 0};
    int first_out [2] = '{-1, -1};

    gsim_sched_if bus_a ();
    gsim_sched_if bus_b ();

    gsim_sched #(.NR_ITER(84), .PE_LAT(2)) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(bus_a));
    gsim_sched #(.NR_ITER(1),  .PE_LAT(3)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
            $fatal(1);
        end
    end

    task automatic chk(input string nm, input int i, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s inst%0d cyc%0d: got %0d, expected %0d", nm, i, cyc, act, exp_v);
        end
    endtask

    function automatic view_t obs(input int i);
        view_t v;
        if (i == 0) begin
            v.rst_n = int'(rst_a_n);          v.in_en = int'(bus_a.in_en);
            v.b_we = int'(bus_a.b_we);         v.b_addr = int'(bus_a.b_addr);
            v.pe_issue = int'(bus_a.pe_issue); v.row0 = int'(bus_a.pe_row0);
            v.row1 = int'(bus_a.pe_row1);      v.x_we = int'(bus_a.x_we);
            v.wa0 = int'(bus_a.x_waddr0);      v.wa1 = int'(bus_a.x_waddr1);
            v.sweep = int'(bus_a.sweep_cnt);   v.out_valid = int'(bus_a.out_valid);
            v.out_addr = int'(bus_a.out_addr); v.busy = int'(bus_a.busy);
        end else begin
            v.rst_n = int'(rst_b_n);          v.in_en = int'(bus_b.in_en);
            v.b_we = int'(bus_b.b_we);         v.b_addr = int'(bus_b.b_addr);
            v.pe_issue = int'(bus_b.pe_issue); v.row0 = int'(bus_b.pe_row0);
            v.row1 = int'(bus_b.pe_row1);      v.x_we = int'(bus_b.x_we);
            v.wa0 = int'(bus_b.x_waddr0);      v.wa1 = int'(bus_b.x_waddr1);
            v.sweep = int'(bus_b.sweep_cnt);   v.out_valid = int'(bus_b.out_valid);
            v.out_addr = int'(bus_b.out_addr); v.busy = int'(bus_b.busy);
        end
        return v;
    endfunction

    // Outputs as a function of samples loaded and cycles elapsed since the solve began.
    function automatic view_t model(input int i, input int t, input int in_en);
        view_t e = '{default: 0};
        int p = 8 + LATV[i];
        int s = NRV[i] * p;
        int k, j;
        if (mdl_ld[i] < 16) begin
            e.b_we   = in_en;
            e.b_addr = mdl_ld[i];
            e.busy   = (mdl_ld[i] > 0);
        end else begin
            k = t - mdl_start[i];
            e.busy = 1;
            if (k < s) begin
                e.pe_issue = ((k % p) < 8);
                if (e.pe_issue != 0) begin
                    e.row0 = k % p;
                    e.row1 = k % p + 8;
                end
                e.sweep = k / p + (((k % p) == p - 1) ? 1 : 0);
            end else begin
                e.out_valid = 1;
                e.out_addr  = k - s;
                e.sweep     = NRV[i];
            end
            j = k - LATV[i];
            if (j >= 0 && j < s && (j % p) < 8) begin
                e.x_we = 1;
                e.wa0  = j % p;
                e.wa1  = j % p + 8;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        view_t o, e;
        for (int i = 0; i < 2; i++) begin
            o = obs(i);
            if (o.rst_n == 0) mdl_ld[i] = 0;
            e = model(i, cyc, o.in_en);
            chk("b_we", i, o.b_we, e.b_we);
            chk("b_addr", i, o.b_addr, e.b_addr);
            chk("pe_issue", i, o.pe_issue, e.pe_issue);
            chk("pe_row0", i, o.row0, e.row0);
            chk("pe_row1", i, o.row1, e.row1);
            chk("x_we", i, o.x_we, e.x_we);
            chk("x_waddr0", i, o.wa0, e.wa0);
            chk("x_waddr1", i, o.wa1, e.wa1);
            chk("sweep_cnt", i, o.sweep, e.sweep);
            chk("out_valid", i, o.out_valid, e.out_valid);
            chk("out_addr", i, o.out_addr, e.out_addr);
            chk("busy", i, o.busy, e.busy);
            if (o.rst_n != 0) begin
                if (mdl_ld[i] < 16) begin
                    if (o.in_en != 0) begin
                        mdl_ld[i]++;
                        if (mdl_ld[i] == 16) begin
                            mdl_start[i] = cyc + 1;
                            n_iss[i] = 0;
                            n_xwe[i] = 0;
                            first_out[i] = -1;
                        end
                    end
                end else begin
                    if (o.pe_issue != 0) n_iss[i]++;
                    if (o.x_we != 0) n_xwe[i]++;
                    if (o.out_valid != 0 && first_out[i] < 0) first_out[i] = cyc;
                    if (cyc - mdl_start[i] == NRV[i] * (8 + LATV[i]) + 15) begin
                        chk("issue_total", i, n_iss[i], LIT_ISS[i]);
                        chk("xwe_total", i, n_xwe[i], LIT_ISS[i]);
                        chk("out_latency", i, first_out[i] - (mdl_start[i] - 1), LIT_LAT[i]);
                        mdl_ld[i] = 0;
                    end
                end
            end
        end
    end

    task automatic drive_a();
        int acc = 0;
        int c = 0;
        repeat (5) begin @(posedge clk); #1; bus_a.in_en = 1'b0; end
        // Gapped load: every third cycle idle.
        while (acc < 16) begin
            @(posedge clk); #1;
            bus_a.in_en = ((c % 3) != 2);
            if (bus_a.in_en) acc++;
            c++;
        end
        // Stray in_en through the whole solve, then a back-to-back second load.
        repeat (872) begin @(posedge clk); #1; bus_a.in_en = 1'b1; end
        repeat (94) begin @(posedge clk); #1; bus_a.in_en = 1'b0; end
        @(posedge clk); #1;
        chk("mid_row0", 0, int'(bus_a.pe_row0), 4);
        chk("mid_row1", 0, int'(bus_a.pe_row1), 12);
        chk("mid_sweep", 0, int'(bus_a.sweep_cnt), 9);
        rst_a_n = 1'b0;
        #1;
        chk("rst_issue", 0, int'(bus_a.pe_issue), 0);
        chk("rst_xwe", 0, int'(bus_a.x_we), 0);
        chk("rst_sweep", 0, int'(bus_a.sweep_cnt), 0);
        chk("rst_busy", 0, int'(bus_a.busy), 0);
        repeat (2) @(posedge clk);
        #1; rst_a_n = 1'b1;
        repeat (3) @(posedge clk);
        repeat (16) begin @(posedge clk); #1; bus_a.in_en = 1'b1; end
        @(posedge clk); #1; bus_a.in_en = 1'b0;
        repeat (25) @(posedge clk);
    endtask

    task automatic drive_b();
        int lb;
        repeat (5) begin @(posedge clk); #1; bus_b.in_en = 1'b0; end
        repeat (16) begin @(posedge clk); #1; bus_b.in_en = 1'b1; end
        lb = cyc;
        @(posedge clk); #1; bus_b.in_en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("short_sweep_l10", 1, int'(bus_b.sweep_cnt), 0);
        chk("short_xwa0_l10", 1, int'(bus_b.x_waddr0), 6);
        @(posedge clk); #1;
        chk("short_sweep_l11", 1, int'(bus_b.sweep_cnt), 1);
        chk("short_xwa1_l11", 1, int'(bus_b.x_waddr1), 15);
        @(posedge clk); #1;
        chk("short_outv_l12", 1, int'(bus_b.out_valid), 1);
        chk("short_xwe_l12", 1, int'(bus_b.x_we), 0);
        chk("short_lat", 1, cyc - lb, 12);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        bus_a.in_en = 1'b0;
        bus_b.in_en = 1'b0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 0, int'(bus_a.busy), 0);
        chk("reset_outv", 1, int'(bus_b.out_valid), 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        fork
            drive_a();
            drive_b();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gsim_sched.md
# gsim_sched

Sequencer for the Gauss-Seidel solver datapath. It accepts the 16-word b vector, runs a fixed number of sweeps over the two PEs, then streams the solution out. It owns all timing inside the solver: b-buffer writes, PE issue slots with row indices, x-buffer writebacks aligned to PE latency, sweep counting, and the output window. It sits between the top-level handshake (`in_en` / `out_valid`) and the PE pair plus its b/x storage.

## Interface
- `N`, 16: unknowns per system. Must be even.
- `NR_ITER`, 84: sweeps per solve. Range 1..127.
- `PE_LAT`, 2: PE input-to-result latency in cycles. Must be ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_en` in 1: one b sample is valid this cycle.
- `b_we` out 1: write strobe to the b buffer.
- `b_addr` out 4: b buffer write index.
- `pe_issue` out 1: both PEs accept operands this cycle.
- `pe_row0` out 4: row issued to PE0.
- `pe_row1` out 4: row issued to PE1.
- `x_we` out 1: write PE results into the x buffer.
- `x_waddr0` out 4: x buffer write index for the PE0 result.
- `x_waddr1` out 4: x buffer write index for the PE1 result.
- `sweep_cnt` out 7: number of completed sweeps.
- `out_valid` out 1: `x_out` carries x[`out_addr`].
- `out_addr` out 4: x buffer read index during output.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, CALC, DRAIN, OUT.
- **IDLE**
  - `in_en`=1 → write sample 0 this cycle: `b_we`=1, `b_addr`=0. Go to LOAD with `ld_cnt`=1.
- **LOAD**
  - `b_we`=`in_en` (Mealy), `b_addr`=`ld_cnt`.
  - `ld_cnt` advances only on accepted samples. Gaps in `in_en` stall the load and do not abort it.
  - The accepted sample at index 15 moves the FSM to CALC on the next cycle.
- **CALC** (N/2 = 8 cycles, slot s = 0..7)
  - `pe_issue`=1, `pe_row0`=s, `pe_row1`=s+8.
  - Rows 8 apart issue in the same slot, so their stencil neighbourhoods (±3) are independent.
  - After slot 7, go to DRAIN.
- **DRAIN** (`PE_LAT` cycles)
  - `pe_issue`=0.
  - On the last DRAIN cycle `sweep_cnt` increments. If the new count equals `NR_ITER`, go to OUT; otherwise go to CALC at slot 0.
- **Writeback**
  - `x_we`, `x_waddr0` and `x_waddr1` equal `pe_issue`, `pe_row0` and `pe_row1` delayed exactly `PE_LAT` cycles.
  - The delay line is not gated by state, so the last writeback of a sweep lands on the last DRAIN cycle.
- **OUT** (16 cycles)
  - `out_valid`=1, `out_addr`=0..15 in order.
  - After index 15, return to IDLE and clear `sweep_cnt`.
- `in_en` is ignored in CALC, DRAIN and OUT. No b write occurs in those states.
- `b_addr` and `x_waddr*` are 4 bits. Counters saturate by FSM exit, never by wrap-around.

## Timing
- **Reset values:** all outputs 0, state IDLE, all counters 0, delay line cleared.
- **Reset mid-operation:** assertion of `rst_n` clears everything immediately, including in-flight writebacks. After release the block waits in IDLE.
- **Outputs:** `pe_*`, `x_*`, `out_*`, `busy` and `sweep_cnt` are registered. Only `b_we` and `b_addr` are combinational on `in_en`.
- **Sweep period:** 8 + `PE_LAT` cycles (10 at defaults).
- **Latency:**
  - If the 16th sample is accepted in cycle L, the first `pe_issue` is in cycle L+1.
  - The first `out_valid` is in cycle L+1+`NR_ITER`·(8+`PE_LAT`). At defaults this is L+841.
- **Back-to-back solves:** `in_en` in the cycle right after the last `out_valid` is accepted, because the FSM is already in IDLE.

## Structure
- `gsim_pkg` holds:
  - the state enum,
  - `N`,
  - `N_HALF`,
  - row-index width (4),
  - sweep counter width (7).
- Sub-module `gsim_wb_delay` is a `PE_LAT`-deep shift register carrying {issue, row0, row1} that produces `x_we` and `x_waddr0`/`x_waddr1`. It uses async active-low clear.
- The FSM and counters live in `gsim_sched`.

## Test plan
- **Reset:** hold `rst_n`=0, then release. Expect every output 0 and `busy`=0 for 5 cycles with `in_en`=0.
- **Gapped load:** 16 samples with `in_en` low every third cycle. Expect `b_addr` 0..15 with `b_we` only on accepted cycles, and the first `pe_issue` exactly 1 cycle after the 16th sample.
- **Full solve at defaults:**
  - Count 84·8 = 672 `pe_issue` cycles and 672 `x_we` cycles.
  - Each `x_we` appears 2 cycles after its issue, with `x_waddr0` = `pe_row0` and `x_waddr1` = `pe_row1`.
  - First `out_valid` at L+841, 16 valid cycles with `out_addr` 0..15, then `busy`=0.
- **Short solve (`NR_ITER`=1, `PE_LAT`=3):**
  - One sweep of 11 cycles, `sweep_cnt`=1 on the last DRAIN cycle, `out_valid` at L+12.
- **Reset mid-solve:** assert `rst_n`=0 during CALC slot 4 of sweep 10. Expect all outputs 0 in the same cycle, no `x_we` afterwards, and a clean new load accepted after release.
- **Stray input:** drive `in_en`=1 throughout CALC, DRAIN and OUT. Expect no `b_we`, and a second solve starting in the cycle after the last `out_valid`.
